hazard_ctrl: RTL and testbench
==============================

// Module: hazard_ctrl
// PURPOSE
//  Parametrised hazard/forwarding controller for the 5-stage cpu pipeline (if/id/ex/mem/wb).
//  Resolves RAW hazards seen by decode: forwards EX/MEM and MEM/WB results into the rs/rt operands, or stalls.
//  Squashes wrong-path fetches after a jump.
//  Keeps a saturating stall-cycle counter.
//  Sits beside decode; drives the operand muxes, stall/flush enables of fetch/decode and the bubble into execute.
// PARAMETERS
//  DATA_W       32  operand/result width
//  REG_AW       5   register address width; address 0 is hardwired zero, never a hazard
//  FLUSH_SLOTS  1   IF/ID slots squashed after a taken jump (0 = MIPS delay-slot semantics)
//  STALL_CNT_W  16  width of the stall-cycle performance counter
// PORTS
//  clk          in   1       rising-edge clock
//  rst          in   1       asynchronous, active-high reset
//  id_rs_addr   in   REG_AW  rs read address in ID
//  id_rt_addr   in   REG_AW  rt read address in ID
//  id_rs_used   in   1       instruction in ID reads rs
//  id_rt_used   in   1       instruction in ID reads rt
//  id_jump      in   1       decode resolved a taken jump this cycle
//  rf_rs_data   in   DATA_W  regfile rs read data
//  rf_rt_data   in   DATA_W  regfile rt read data
//  ex_rd_en     in   1       ID/EX producer writes rd
//  ex_rd_addr   in   REG_AW  ID/EX rd
//  mem_rd_en    in   1       EX/MEM producer writes rd
//  mem_rd_addr  in   REG_AW  EX/MEM rd
//  mem_is_load  in   1       EX/MEM producer is a load (rd_data_sel)
//  mem_alu_data in   DATA_W  EX/MEM ALU result
//  wb_rd_en     in   1       writeback enable
//  wb_rd_addr   in   REG_AW  writeback address
//  wb_rd_data   in   DATA_W  writeback data
//  rs_data      out  DATA_W  resolved rs operand to decode
//  rt_data      out  DATA_W  resolved rt operand to decode
//  stall        out  1       hold PC and IF/ID; decode keeps its instruction
//  bubble       out  1       load NOP controls into ID/EX (rd_en=0, mem_en=0)
//  flush        out  1       replace IF/ID instruction with NOP
//  stall_cnt    out  STALL_CNT_W  cycles with stall=1, saturates at all-ones
// BEHAVIOUR
//  - Reset: state=RUN; stall=bubble=flush=0; stall_cnt=0.
//    rs_data/rt_data remain combinational.
//  - match(stage,x) = stage_rd_en & id_x_used & (stage_rd_addr==id_x_addr) & (id_x_addr!=0).
//  - Operand select, per rs/rt, in priority order:
//    EX/MEM non-load match -> mem_alu_data; else WB match -> wb_rd_data; else rf data.
//  - WB bypass is unconditional; regfile read/write ordering is irrelevant.
//  - stall = match(ex) | (match(mem) & mem_is_load). bubble = stall. Purely combinational, same cycle.
//  - Load-use hazard, load still in ID/EX: 2 stall cycles.
//  - ALU-use hazard, producer in ID/EX: 1 stall cycle.
//  - FSM RUN/FLUSH, registered:
//    - RUN & id_jump & !stall & FLUSH_SLOTS>0 -> FLUSH with cnt=FLUSH_SLOTS-1. flush=1 in each FLUSH cycle.
//    - FLUSH: cnt==0 -> RUN, else cnt-1.
//    - id_jump while stall=1 is ignored; decode re-asserts it after the stall.
//    - id_jump arriving in FLUSH is ignored; it is wrong-path.
//  - stall_cnt increments on every clk with stall=1 and holds at 2^STALL_CNT_W-1.
//  - Async rst mid-FLUSH or mid-stall returns to RUN immediately; no partial flush is replayed.
// CONFIGURATION
//  HAZARD_CTRL_FORWARDING_EN defined:
//    EX/MEM and WB forwarding as above.
//  Undefined:
//    no EX/MEM forwarding (WB bypass kept);
//    stall = match(ex) | match(mem), independent of mem_is_load.
//    Every RAW on an in-flight producer costs 1-2 stall cycles.
// STRUCTURE
//  - Shared package cpu_pkg: REG_AW, DATA_W, REG_ZERO constant, typedef of the FSM state enum {RUN, FLUSH}.
//  - One natural sub-module: hazard_fwd_mux, the per-operand match/priority select.
//    It is instantiated twice (rs, rt); the FSM and counter stay in hazard_ctrl.
// TESTING
//  1. rst high, then released -> stall=bubble=flush=0, stall_cnt=0.
//     Operands equal rf data.
//  2. EX/MEM: rd_en=1, addr=5, not a load, mem_alu_data=0x1234.
//     ID reads rs=5, rf=0 -> rs_data=0x1234, stall=0.
//     Macro undefined -> stall=1.
//  3. ex_rd_addr=7 holds the load; ID uses rt=7.
//     -> stall=1 two cycles, then rt_data=wb_rd_data; stall_cnt=2.
//  4. id_rs_addr=0 with all stages writing reg 0 -> no stall; rs_data=rf_rs_data.
//  5. id_jump pulse, FLUSH_SLOTS=2 -> flush=1 for exactly 2 cycles.
//     Second jump during FLUSH is ignored.
//     rst mid-FLUSH -> flush=0 at once.
//  6. Force stall for 2^STALL_CNT_W+3 cycles -> stall_cnt saturates at all-ones.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared pipeline constants and the hazard controller's flush FSM state type.
package cpu_pkg;
  localparam int DATA_W   = 32;
  localparam int REG_AW   = 5;
  localparam int REG_ZERO = 0;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } hz_state_t;
endpackage

// File: rtl/hazard_fwd_mux.sv
// Per-operand producer match and forwarding select.
// Optional EX/MEM forwarding: HAZARD_CTRL_FORWARDING_EN.
module hazard_fwd_mux
  import cpu_pkg::*;
#(
  parameter int DW = DATA_W,
  parameter int AW = REG_AW
) (
  input  logic [AW-1:0] id_addr,
  input  logic          id_used,
  input  logic [DW-1:0] rf_data,
  input  logic          ex_rd_en,
  input  logic [AW-1:0] ex_rd_addr,
  input  logic          mem_rd_en,
  input  logic [AW-1:0] mem_rd_addr,
  input  logic          mem_is_load,
  input  logic [DW-1:0] mem_alu_data,
  input  logic          wb_rd_en,
  input  logic [AW-1:0] wb_rd_addr,
  input  logic [DW-1:0] wb_rd_data,
  output logic [DW-1:0] data,
  output logic          ex_hit,
  output logic          mem_hit
);
  logic live;
  logic wb_hit;

  // Register zero is hardwired, so it never creates a dependency.
  assign live    = id_used && (id_addr != AW'(REG_ZERO));
  assign ex_hit  = live && ex_rd_en  && (ex_rd_addr  == id_addr);
  assign mem_hit = live && mem_rd_en && (mem_rd_addr == id_addr);
  assign wb_hit  = live && wb_rd_en  && (wb_rd_addr  == id_addr);

`ifdef HAZARD_CTRL_FORWARDING_EN
  always_comb begin
    data = rf_data;
    if (mem_hit && !mem_is_load) data = mem_alu_data;
    else if (wb_hit)             data = wb_rd_data;
  end
`else
  logic unused_mem;
  assign unused_mem = (^mem_alu_data) ^ mem_is_load;

  always_comb begin
    data = rf_data;
    if (wb_hit) data = wb_rd_data;
  end
`endif
endmodule

// File: rtl/hazard_ctrl.sv
// Hazard/forwarding controller: operand bypass, RAW stall, post-jump flush, stall counter.
// Optional EX/MEM forwarding: HAZARD_CTRL_FORWARDING_EN.
module hazard_ctrl
  import cpu_pkg::*;
#(
  parameter int DATA_W      = cpu_pkg::DATA_W,
  parameter int REG_AW      = cpu_pkg::REG_AW,
  parameter int FLUSH_SLOTS = 1,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [REG_AW-1:0]      id_rs_addr,
  input  logic [REG_AW-1:0]      id_rt_addr,
  input  logic                   id_rs_used,
  input  logic                   id_rt_used,
  input  logic                   id_jump,
  input  logic [DATA_W-1:0]      rf_rs_data,
  input  logic [DATA_W-1:0]      rf_rt_data,
  input  logic                   ex_rd_en,
  input  logic [REG_AW-1:0]      ex_rd_addr,
  input  logic                   mem_rd_en,
  input  logic [REG_AW-1:0]      mem_rd_addr,
  input  logic                   mem_is_load,
  input  logic [DATA_W-1:0]      mem_alu_data,
  input  logic                   wb_rd_en,
  input  logic [REG_AW-1:0]      wb_rd_addr,
  input  logic [DATA_W-1:0]      wb_rd_data,
  output logic [DATA_W-1:0]      rs_data,
  output logic [DATA_W-1:0]      rt_data,
  output logic                   stall,
  output logic                   bubble,
  output logic                   flush,
  output logic [STALL_CNT_W-1:0] stall_cnt
);
  localparam int CNT_W = (FLUSH_SLOTS > 1) ? $clog2(FLUSH_SLOTS) : 1;

  logic rs_ex_hit, rs_mem_hit, rt_ex_hit, rt_mem_hit;
  hz_state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  hazard_fwd_mux #(.DW(DATA_W), .AW(REG_AW)) u_rs (
    .id_addr(id_rs_addr), .id_used(id_rs_used), .rf_data(rf_rs_data),
    .ex_rd_en(ex_rd_en), .ex_rd_addr(ex_rd_addr),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_is_load(mem_is_load),
    .mem_alu_data(mem_alu_data),
    .wb_rd_en(wb_rd_en), .wb_rd_addr(wb_rd_addr), .wb_rd_data(wb_rd_data),
    .data(rs_data), .ex_hit(rs_ex_hit), .mem_hit(rs_mem_hit)
  );

  hazard_fwd_mux #(.DW(DATA_W), .AW(REG_AW)) u_rt (
    .id_addr(id_rt_addr), .id_used(id_rt_used), .rf_data(rf_rt_data),
    .ex_rd_en(ex_rd_en), .ex_rd_addr(ex_rd_addr),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_is_load(mem_is_load),
    .mem_alu_data(mem_alu_data),
    .wb_rd_en(wb_rd_en), .wb_rd_addr(wb_rd_addr), .wb_rd_data(wb_rd_data),
    .data(rt_data), .ex_hit(rt_ex_hit), .mem_hit(rt_mem_hit)
  );

`ifdef HAZARD_CTRL_FORWARDING_EN
  assign stall = rs_ex_hit || rt_ex_hit || ((rs_mem_hit || rt_mem_hit) && mem_is_load);
`else
  assign stall = rs_ex_hit || rt_ex_hit || rs_mem_hit || rt_mem_hit;
`endif
  assign bubble = stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // A jump under stall or inside a flush window is dropped; decode re-issues it if real.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    flush   = 1'b0;
    case (state_q)
      RUN: begin
        if (id_jump && !stall && (FLUSH_SLOTS > 0)) begin
          state_d = FLUSH;
          cnt_d   = CNT_W'(FLUSH_SLOTS - 1);
        end
      end
      FLUSH: begin
        flush = 1'b1;
        if (cnt_q == '0) state_d = RUN;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                            stall_cnt <= '0;
    else if (stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
  end
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed testbench for hazard_ctrl (FLUSH_SLOTS=2, 4-bit stall counter).
module tb_hazard_ctrl;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst;
  logic [AW-1:0] id_rs_addr, id_rt_addr, ex_rd_addr, mem_rd_addr, wb_rd_addr;
  logic id_rs_used, id_rt_used, id_jump, ex_rd_en, mem_rd_en, mem_is_load, wb_rd_en;
  logic [DW-1:0] rf_rs_data, rf_rt_data, mem_alu_data, wb_rd_data, rs_data, rt_data;
  logic stall, bubble, flush;
  logic [CW-1:0] stall_cnt;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.DATA_W(DW), .REG_AW(AW), .FLUSH_SLOTS(2), .STALL_CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_jump(id_jump),
    .rf_rs_data(rf_rs_data), .rf_rt_data(rf_rt_data),
    .ex_rd_en(ex_rd_en), .ex_rd_addr(ex_rd_addr),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_is_load(mem_is_load),
    .mem_alu_data(mem_alu_data),
    .wb_rd_en(wb_rd_en), .wb_rd_addr(wb_rd_addr), .wb_rd_data(wb_rd_data),
    .rs_data(rs_data), .rt_data(rt_data),
    .stall(stall), .bubble(bubble), .flush(flush), .stall_cnt(stall_cnt)
  );

  task automatic idle();
    id_rs_addr = '0; id_rt_addr = '0; id_rs_used = 0; id_rt_used = 0; id_jump = 0;
    rf_rs_data = 32'h1111_0000; rf_rt_data = 32'h2222_0000;
    ex_rd_en = 0; ex_rd_addr = '0; mem_rd_en = 0; mem_rd_addr = '0; mem_is_load = 0;
    mem_alu_data = 32'h0; wb_rd_en = 0; wb_rd_addr = '0; wb_rd_data = 32'h0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    id_rs_used = 1; id_rs_addr = 5'd3; id_rt_used = 1; id_rt_addr = 5'd4;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({stall, bubble, flush} !== 3'b000) begin
      failures++; $display("FAIL reset_ctrl got=%b exp=000", {stall, bubble, flush});
    end
    checks++;
    if (stall_cnt !== 4'd0) begin
      failures++; $display("FAIL reset_cnt got=%0d exp=0", stall_cnt);
    end
    checks++;
    if (rs_data !== 32'h1111_0000 || rt_data !== 32'h2222_0000) begin
      failures++; $display("FAIL reset_operands rs=%h rt=%h exp=11110000/22220000", rs_data, rt_data);
    end
  endtask

  task automatic test_fwd_mem();
    do_reset();
    @(negedge clk);
    id_rs_used = 1; id_rs_addr = 5'd5; rf_rs_data = 32'h0;
    mem_rd_en = 1; mem_rd_addr = 5'd5; mem_is_load = 0; mem_alu_data = 32'h1234;
    #1;
    checks++;
`ifdef HAZARD_CTRL_FORWARDING_EN
    if (rs_data !== 32'h1234 || stall !== 1'b0) begin
      failures++; $display("FAIL fwd_mem rs=%h stall=%b exp=1234/0", rs_data, stall);
    end
`else
    if (stall !== 1'b1 || bubble !== 1'b1) begin
      failures++; $display("FAIL fwd_mem_nofwd stall=%b bubble=%b exp=1/1", stall, bubble);
    end
`endif
    // Both EX/MEM and WB hold r5: EX/MEM is younger and wins when forwarding.
    wb_rd_en = 1; wb_rd_addr = 5'd5; wb_rd_data = 32'h9999;
    #1;
    checks++;
`ifdef HAZARD_CTRL_FORWARDING_EN
    if (rs_data !== 32'h1234) begin
      failures++; $display("FAIL fwd_priority rs=%h exp=1234", rs_data);
    end
`else
    if (rs_data !== 32'h9999) begin
      failures++; $display("FAIL fwd_priority rs=%h exp=9999", rs_data);
    end
`endif
    mem_rd_en = 0; id_rt_used = 1; id_rt_addr = 5'd5; rf_rt_data = 32'h7;
    #1;
    checks++;
    if (rs_data !== 32'h9999 || rt_data !== 32'h9999 || stall !== 1'b0) begin
      failures++; $display("FAIL fwd_wb rs=%h rt=%h stall=%b exp=9999/9999/0", rs_data, rt_data, stall);
    end
    id_rt_used = 0;
    #1;
    checks++;
    if (rt_data !== 32'h7) begin
      failures++; $display("FAIL unused_rt rt=%h exp=7", rt_data);
    end
  endtask

  task automatic test_alu_use();
    do_reset();
    @(negedge clk);
    id_rs_used = 1; id_rs_addr = 5'd9; ex_rd_en = 1; ex_rd_addr = 5'd9;
    #1;
    checks++;
    if (stall !== 1'b1 || bubble !== 1'b1) begin
      failures++; $display("FAIL alu_use_stall stall=%b bubble=%b exp=1/1", stall, bubble);
    end
    @(negedge clk);
    ex_rd_en = 0; mem_rd_en = 1; mem_rd_addr = 5'd9; mem_is_load = 0; mem_alu_data = 32'hCAFE;
    #1;
    checks++;
`ifdef HAZARD_CTRL_FORWARDING_EN
    if (stall !== 1'b0 || rs_data !== 32'hCAFE || stall_cnt !== 4'd1) begin
      failures++; $display("FAIL alu_use_after stall=%b rs=%h cnt=%0d exp=0/cafe/1", stall, rs_data, stall_cnt);
    end
`else
    if (stall !== 1'b1 || stall_cnt !== 4'd1) begin
      failures++; $display("FAIL alu_use_after stall=%b cnt=%0d exp=1/1", stall, stall_cnt);
    end
`endif
  endtask

  task automatic test_load_use();
    do_reset();
    @(negedge clk);
    id_rt_used = 1; id_rt_addr = 5'd7; rf_rt_data = 32'hAAAA;
    ex_rd_en = 1; ex_rd_addr = 5'd7;
    #1;
    checks++;
    if (stall !== 1'b1) begin
      failures++; $display("FAIL load_use_c1 stall=%b exp=1", stall);
    end
    @(negedge clk);
    ex_rd_en = 0; mem_rd_en = 1; mem_rd_addr = 5'd7; mem_is_load = 1; mem_alu_data = 32'hDEAD;
    #1;
    checks++;
    if (stall !== 1'b1 || rt_data !== 32'hAAAA) begin
      failures++; $display("FAIL load_use_c2 stall=%b rt=%h exp=1/aaaa", stall, rt_data);
    end
    @(negedge clk);
    mem_rd_en = 0; mem_is_load = 0; wb_rd_en = 1; wb_rd_addr = 5'd7; wb_rd_data = 32'h5555;
    #1;
    checks++;
    if (stall !== 1'b0 || rt_data !== 32'h5555 || stall_cnt !== 4'd2) begin
      failures++; $display("FAIL load_use_done stall=%b rt=%h cnt=%0d exp=0/5555/2", stall, rt_data, stall_cnt);
    end
  endtask

  task automatic test_zero_reg();
    do_reset();
    @(negedge clk);
    id_rs_used = 1; id_rs_addr = 5'd0; rf_rs_data = 32'h77;
    ex_rd_en = 1; mem_rd_en = 1; mem_is_load = 1; wb_rd_en = 1;
    mem_alu_data = 32'hBAD1; wb_rd_data = 32'hBAD2;
    #1;
    checks++;
    if (stall !== 1'b0 || rs_data !== 32'h77) begin
      failures++; $display("FAIL zero_reg stall=%b rs=%h exp=0/77", stall, rs_data);
    end
  endtask

  task automatic test_flush();
    do_reset();
    @(negedge clk);
    id_jump = 1;
    #1;
    checks++;
    if (flush !== 1'b0) begin
      failures++; $display("FAIL flush_early got=%b exp=0", flush);
    end
    @(negedge clk);
    id_jump = 0;
    checks++;
    if (flush !== 1'b1) begin
      failures++; $display("FAIL flush_slot1 got=%b exp=1", flush);
    end
    @(negedge clk);
    id_jump = 1;
    checks++;
    if (flush !== 1'b1) begin
      failures++; $display("FAIL flush_slot2 got=%b exp=1", flush);
    end
    @(negedge clk);
    id_jump = 0;
    checks++;
    if (flush !== 1'b0) begin
      failures++; $display("FAIL flush_jump_ignored got=%b exp=0", flush);
    end
    // Jump under a stall must not open a flush window.
    id_jump = 1; id_rs_used = 1; id_rs_addr = 5'd3; ex_rd_en = 1; ex_rd_addr = 5'd3;
    @(negedge clk);
    id_jump = 0; ex_rd_en = 0;
    checks++;
    if (flush !== 1'b0) begin
      failures++; $display("FAIL flush_under_stall got=%b exp=0", flush);
    end
    id_jump = 1;
    @(negedge clk);
    id_jump = 0;
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (flush !== 1'b0) begin
      failures++; $display("FAIL flush_async_rst got=%b exp=0", flush);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (flush !== 1'b0) begin
      failures++; $display("FAIL flush_no_replay got=%b exp=0", flush);
    end
  endtask

  task automatic test_saturate();
    do_reset();
    @(negedge clk);
    id_rs_used = 1; id_rs_addr = 5'd12; ex_rd_en = 1; ex_rd_addr = 5'd12;
    repeat (14) @(negedge clk);
    checks++;
    if (stall_cnt !== 4'd14) begin
      failures++; $display("FAIL cnt_count got=%0d exp=14", stall_cnt);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (stall_cnt !== 4'd15) begin
      failures++; $display("FAIL cnt_saturate got=%0d exp=15", stall_cnt);
    end
    ex_rd_en = 0;
    @(negedge clk);
    checks++;
    if (stall_cnt !== 4'd15 || stall !== 1'b0) begin
      failures++; $display("FAIL cnt_hold got=%0d stall=%b exp=15/0", stall_cnt, stall);
    end
  endtask

  initial begin
    test_reset();
    test_fwd_mem();
    test_alu_use();
    test_load_use();
    test_zero_reg();
    test_flush();
    test_saturate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
